// File: rtl/port_arbiter.sv
// Wormhole output-port arbiter: round-robin grant among N_REQ requesters,
// locked to one owner from the first flit until its tail flit transfers.
module port_arbiter #(
    parameter int N_REQ  = 5,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [N_REQ-1:0]        grant,
    output logic [15:0]             flit_cnt
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t        state, state_next;
    logic [PW-1:0] ptr;
    logic [PW-1:0] own_idx;
    logic [PW-1:0] win_idx;
    logic          win_found;
    logic          xfer;
    int            idx;

    // Round-robin scan starting just after the last packet's owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_found) state_next = LOCKED;
            LOCKED:  if (xfer && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Owner's channel is routed straight through; nobody else sees ready.
    always_comb begin
        out_valid = 1'b0;
        req_ready = '0;
        out_data  = req_data[int'(own_idx)*DATA_W +: DATA_W];
        out_last  = req_last[own_idx];
        if (state == LOCKED) begin
            out_valid          = req_valid[own_idx];
            req_ready[own_idx] = out_ready;
        end
    end

    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= PW'(N_REQ - 1);
            own_idx <= '0;
            grant   <= '0;
        end else if (state == IDLE && win_found) begin
            own_idx <= win_idx;
            grant   <= N_REQ'(1) << win_idx;
        end else if (state == LOCKED && xfer && out_last) begin
            ptr     <= own_idx;
            grant   <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            flit_cnt <= '0;
        else if (xfer && flit_cnt != 16'hFFFF) flit_cnt <= flit_cnt + 16'd1;
    end
endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter N_REQ, default 5, SHALL be the number of requesters sharing one output link (N, S, E, W, local).
REQ-002 Parameter DATA_W, default 32, SHALL be the flit payload width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 req_valid  input  N_REQ  SHALL be the per-requester flit valid.
REQ-006 req_data  input  N_REQ*DATA_W  SHALL be the per-requester flit payload; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-007 req_last  input  N_REQ  SHALL mark the tail flit of a packet.
REQ-008 req_ready  output  N_REQ  SHALL be the per-requester accept.
REQ-009 out_valid  output  1  SHALL be the output-link flit valid.
REQ-010 out_data  output  DATA_W  SHALL be the output-link flit payload.
REQ-011 out_last  output  1  SHALL be the output-link tail marker.
REQ-012 out_ready  input  1  SHALL be the downstream accept.
REQ-013 grant  output  N_REQ  SHALL be the one-hot current owner; all-zero when idle.
REQ-014 flit_cnt  output  16  SHALL count flits transferred on the output link, saturating at 16'hFFFF.

Function
REQ-015 Transfer SHALL occur on a cycle where out_valid && out_ready; requester transfer where req_valid[k] && req_ready[k].
REQ-016 FSM SHALL have two states: IDLE and LOCKED.
REQ-017 In IDLE: grant=0, out_valid=0, req_ready=0; no flit SHALL be transferred.
REQ-018 In IDLE with any req_valid set: winner = first valid requester scanning ptr+1, ptr+2, ... modulo N_REQ; next edge SHALL load grant with winner and enter LOCKED (1-cycle arbitration latency).
REQ-019 In IDLE with no req_valid: state, ptr, grant SHALL hold.
REQ-020 In LOCKED with owner g: out_valid=req_valid[g], out_data=req_data[g], out_last=req_last[g], req_ready[g]=out_ready, req_ready of every other requester SHALL be 0 (combinational path, zero latency).
REQ-021 Grant SHALL hold across all flits of a packet regardless of other requests (wormhole lock); no preemption.
REQ-022 Transfer with out_last=1 SHALL, at that edge, set ptr=g, clear grant and return to IDLE.
REQ-023 Requests pending at tail-transfer cycle SHALL be arbitrated in the following IDLE cycle (exactly one bubble cycle between packets).
REQ-024 Owner deasserting req_valid mid-packet SHALL leave grant held; out_valid follows req_valid[g].
REQ-025 Single-flit packet (req_last=1 on first flit) SHALL lock for one transfer then return to IDLE.
REQ-026 flit_cnt SHALL increment by 1 on every output transfer and SHALL NOT wrap.
REQ-027 At most one grant bit SHALL ever be set; req_ready SHALL never be set for a non-owner.

Reset
REQ-028 rst=1 SHALL immediately, asynchronously force: state IDLE, grant=0, out_valid=0, req_ready=0, flit_cnt=0, ptr=N_REQ-1 (requester 0 wins first).
REQ-029 Reset mid-packet SHALL abandon the packet; no flit transferred while rst=1; after release arbitration restarts per REQ-018.
REQ-030 out_data and out_last SHALL be don't-care while out_valid=0.

Verification
REQ-031 After reset, req_valid=5'b11111, all req_last=1, out_ready=1 -> grants in order 0,1,2,3,4,0, one flit each, one idle cycle between, flit_cnt=5 after fifth tail.
REQ-032 Req 2 sends 4-flit packet (last on 4th), req 0 asserts valid at flit 2 -> grant stays 5'b00100 for all 4 flits, then grant 5'b00001 after one IDLE cycle.
REQ-033 Owner locked, out_ready=0 for 3 cycles -> out_data stable, req_ready[g]=0, flit_cnt unchanged; out_ready=1 -> transfer resumes.
REQ-034 rst asserted mid-packet between clock edges -> grant=0, out_valid=0 same cycle without waiting for edge; after release with req 3 valid -> grant 5'b01000.
REQ-035 flit_cnt preloaded near saturation via 65540 transfers -> flit_cnt stays 16'hFFFF.
REQ-036 Owner drops req_valid for 2 cycles mid-packet while req 1 valid -> out_valid=0, grant unchanged, packet completes from owner.
